// File: rtl/ifetch_buffer.sv
// ifetch_buffer: instruction-fetch queue between the PC register and decode.
// Accepts PCs, issues word-aligned instruction-memory reads, and returns the
// instructions in request order with their PC tags. A flush empties the queue
// and drops the responses still owed by memory.
module ifetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] pc_in,
    input  logic        pc_in_valid,
    output logic        pc_in_ready,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = AW + 1;
    localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

    // Per-entry lifecycle: EMPTY -> WAIT (PC stored) -> FULL (data returned).
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]    ent_state [DEPTH];
    logic [31:0]   ent_pc    [DEPTH];
    logic [31:0]   ent_data  [DEPTH];

    logic [AW-1:0] alloc_ptr;
    logic [AW-1:0] fill_ptr;
    logic [AW-1:0] head_ptr;
    logic [CW-1:0] alloc_count;     // entries in WAIT or FULL
    logic [CW-1:0] drop_count;      // responses still owed for flushed fetches
    logic [CW-1:0] inflight_count;  // requests issued but not yet answered

    logic          req_valid;
    logic [31:0]   req_addr;
    logic [31:0]   hold_inst;       // last presented head, shown while inst_valid=0
    logic [31:0]   hold_pc;

    logic          accept;
    logic          req_fire;
    logic          deq;
    logic          rsp_drop;
    logic          rsp_fill;
    logic [CW:0]   occupancy;
    logic [CW-1:0] inflight_next;

    // Handshake decode and head presentation.
    // NOTE: every signal of this block gets a value on every path, so no latch is inferred.
    always_comb begin
        occupancy     = {1'b0, alloc_count} + {1'b0, drop_count};
        pc_in_ready   = reset && !flush && (occupancy < DEPTH_C)
                        && (!req_valid || imem_req_ready);
        accept        = pc_in_valid && pc_in_ready;
        req_fire      = req_valid && imem_req_ready;
        inst_valid    = (ent_state[head_ptr] == ST_FULL);
        deq           = inst_valid && inst_ready;
        rsp_drop      = imem_rsp_valid && (drop_count != '0);
        rsp_fill      = imem_rsp_valid && (drop_count == '0);
        inflight_next = inflight_count + CW'(req_fire) - CW'(imem_rsp_valid);
        inst          = inst_valid ? ent_data[head_ptr] : hold_inst;
        inst_pc       = inst_valid ? ent_pc[head_ptr]   : hold_pc;
    end

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = req_addr;

    // Control state: entry states, pointers, counters and the request register.
    // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ent_state      <= '{default: ST_EMPTY};
            alloc_ptr      <= '0;
            fill_ptr       <= '0;
            head_ptr       <= '0;
            alloc_count    <= '0;
            drop_count     <= '0;
            inflight_count <= '0;
            req_valid      <= 1'b0;
            req_addr       <= RESET_PC;
            hold_inst      <= '0;
            hold_pc        <= RESET_PC;
        end else begin
            inflight_count <= inflight_next;
            if (inst_valid) begin
                hold_inst <= ent_data[head_ptr];
                hold_pc   <= ent_pc[head_ptr];
            end
            if (flush) begin
                // Everything still owed by memory after this edge is dropped,
                // including a request that fires in this very cycle.
                ent_state   <= '{default: ST_EMPTY};
                alloc_ptr   <= '0;
                fill_ptr    <= '0;
                head_ptr    <= '0;
                alloc_count <= '0;
                drop_count  <= inflight_next;
                req_valid   <= 1'b0;
            end else begin
                if (req_fire) begin
                    req_valid <= 1'b0;
                end
                if (accept) begin
                    req_valid            <= 1'b1;
                    req_addr             <= {pc_in[31:2], 2'b00};
                    ent_state[alloc_ptr] <= ST_WAIT;
                    alloc_ptr            <= alloc_ptr + AW'(1);
                end
                if (rsp_drop) begin
                    drop_count <= drop_count - CW'(1);
                end else if (rsp_fill) begin
                    ent_state[fill_ptr] <= ST_FULL;
                    fill_ptr            <= fill_ptr + AW'(1);
                end
                if (deq) begin
                    ent_state[head_ptr] <= ST_EMPTY;
                    head_ptr            <= head_ptr + AW'(1);
                end
                alloc_count <= alloc_count + CW'(accept) - CW'(deq);
            end
        end
    end

    // Payload storage: PC written on allocate, instruction written on fill.
    // NOTE: payload arrays are not reset; ent_state alone decides whether an entry is visible.
    always_ff @(posedge clk) begin
        if (accept) begin
            ent_pc[alloc_ptr] <= pc_in;
        end
        if (reset && !flush && rsp_fill) begin
            ent_data[fill_ptr] <= imem_rsp_data;
        end
    end

endmodule
